// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding and the
// Galois LFSR feedback masks for the supported register widths.
package timer_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_PAUSED = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LOAD   = ST_LOAD,
    RUN    = ST_RUN,
    PAUSED = ST_PAUSED,
    DONE   = ST_DONE
  } state_t;

  // Right-shift Galois masks: term x^k maps to bit k-1.
  localparam logic [15:0] TAPS_4  = 16'h000C;  // x^4+x^3+1
  localparam logic [15:0] TAPS_8  = 16'h00B8;  // x^8+x^6+x^5+x^4+1
  localparam logic [15:0] TAPS_16 = 16'hD008;  // x^16+x^15+x^13+x^4+1

  function automatic logic [15:0] lfsr_taps(input int w);
    case (w)
      4:       return TAPS_4;
      16:      return TAPS_16;
      default: return TAPS_8;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Free-running maximal-length Galois LFSR; advances every cycle out of reset.
module lfsr_gen
  import timer_pkg::*;
#(
  parameter int          LFSR_W = 8,
  parameter logic [15:0] SEED   = 16'h00A5
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [LFSR_W-1:0] q
);

  localparam logic [15:0]       TAPS = lfsr_taps(LFSR_W);
  localparam logic [LFSR_W-1:0] MASK = TAPS[LFSR_W-1:0];
  localparam logic [LFSR_W-1:0] INIT = SEED[LFSR_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) q <= INIT;
    else        q <= q[0] ? ((q >> 1) ^ MASK) : (q >> 1);
  end

endmodule

// File: rtl/param_countdown_timer.sv
// Countdown timer with random start value, pause, abort, saturating bonus,
// optional retrigger, one-cycle expiry pulse and sticky gameover flag.
module param_countdown_timer
  import timer_pkg::*;
#(
  parameter int          TICK_CYCLES = 100_000_000,
  parameter int          COUNT_W     = 5,
  parameter int          MIN_COUNT   = 21,
  parameter int          MAX_COUNT   = 30,
  parameter int          LFSR_W      = 8,
  parameter logic [15:0] SEED        = 16'h00A5,
  parameter int          BONUS       = 3,
  parameter int          RETRIGGER   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               trigger,
  input  logic               pause,
  input  logic               abort,
  input  logic               bonus,
  output logic [COUNT_W-1:0] count,
  output logic               running,
  output logic               expired,
  output logic               gameover
);

  localparam int             TW        = $clog2(TICK_CYCLES);
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [31:0]    RANGE32   = 32'(MAX_COUNT - MIN_COUNT + 1);
  localparam logic [31:0]    MIN32     = 32'(MIN_COUNT);
  localparam logic [31:0]    CMAX      = 32'((2 ** COUNT_W) - 1);

  state_t             state;
  logic [COUNT_W-1:0] timer;
  logic [TW-1:0]      tick_cnt;
  logic [LFSR_W-1:0]  lfsr_q;
  logic [COUNT_W-1:0] rand_val;
  logic [COUNT_W-1:0] timer_next;
  logic [31:0]        sum;
  logic               tick_due;

  lfsr_gen #(.LFSR_W(LFSR_W), .SEED(SEED)) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .q    (lfsr_q)
  );

  assign rand_val = COUNT_W'(MIN32 + (32'(lfsr_q) % RANGE32));
  assign tick_due = (state == RUN) && (tick_cnt == TICK_LAST);
  assign running  = (state == RUN) || (state == PAUSED);
  assign count    = running ? timer : '0;

  // Timer never sits at 0 in RUN, so the tick decrement cannot underflow.
  always_comb begin
    sum        = 32'(timer) + (bonus ? 32'(BONUS) : 32'd0) - (tick_due ? 32'd1 : 32'd0);
    timer_next = (sum > CMAX) ? CMAX[COUNT_W-1:0] : sum[COUNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      tick_cnt <= '0;
      expired  <= 1'b0;
      gameover <= 1'b0;
    end else begin
      expired <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (trigger) begin
            state    <= LOAD;
            gameover <= 1'b0;
          end
        end
        LOAD: begin
          if (abort) begin
            state <= IDLE;
            timer <= '0;
          end else begin
            state    <= RUN;
            timer    <= rand_val;
            tick_cnt <= '0;
          end
        end
        RUN, PAUSED: begin
          if (abort) begin
            state    <= IDLE;
            timer    <= '0;
            tick_cnt <= '0;
          end else if (trigger && (RETRIGGER != 0)) begin
            state    <= LOAD;
            tick_cnt <= '0;
          end else begin
            // The edge that enters PAUSED still counts; the resume edge does not.
            if (tick_due)            tick_cnt <= '0;
            else if (state == RUN)   tick_cnt <= tick_cnt + TW'(1);
            if (tick_due && (timer_next == '0)) begin
              state    <= DONE;
              timer    <= '0;
              expired  <= 1'b1;
              gameover <= 1'b1;
            end else begin
              timer <= timer_next;
              state <= pause ? PAUSED : RUN;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
